// File: rtl/pulp_pwr_domain_seq_pkg.sv
// Shared types and constants for the power-domain sequencer.
// Contents:
//   pwr_state_e    - sequencer state encoding
//   pwr_out_t      - per-state output bundle (err is tracked separately)
//   DEF_*_CYCLES   - default cycle counts used as top-level parameter defaults
//   state_outputs  - decode of the output bundle for a given state
//   max_u          - helper used to size the shared down-counter
package pulp_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RST_REL = 3'd3,
    ST_ON      = 3'd4,
    ST_ISO     = 3'd5,
    ST_RST     = 3'd6,
    ST_PWR_DN  = 3'd7
  } pwr_state_e;

  typedef struct packed {
    logic pwr_en;
    logic clamp;
    logic rst_dom_n;
    logic ack;
    logic busy;
  } pwr_out_t;

  localparam int unsigned DEF_ISO_CYCLES     = 4;
  localparam int unsigned DEF_SETTLE_CYCLES  = 8;
  localparam int unsigned DEF_RST_CYCLES     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

  function automatic pwr_out_t state_outputs(input pwr_state_e s);
    pwr_out_t o;
    o = '{pwr_en: 1'b0, clamp: 1'b1, rst_dom_n: 1'b0, ack: 1'b0, busy: 1'b1};
    case (s)
      ST_OFF:     o.busy = 1'b0;
      ST_PWR_UP,
      ST_SETTLE,
      ST_RST:     o.pwr_en = 1'b1;
      ST_RST_REL,
      ST_ISO: begin
        o.pwr_en    = 1'b1;
        o.rst_dom_n = 1'b1;
      end
      ST_ON: begin
        o.pwr_en    = 1'b1;
        o.clamp     = 1'b0;
        o.rst_dom_n = 1'b1;
        o.ack       = 1'b1;
        o.busy      = 1'b0;
      end
      ST_PWR_DN:  o.pwr_en = 1'b0;
      default:    o.busy = 1'b0;
    endcase
    return o;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulp_pwr_domain_seq_if.sv
// Request/acknowledge and power-control signal bundle of the sequencer.
// Signals:
//   req_i       level request (1 = domain on)
//   pwr_good_i  power-switch chain acknowledge, asynchronous
//   pwr_en_o    power-switch enable
//   clamp_o     isolation clamp (1 = domain outputs clamped to 0)
//   rst_dom_no  active-low domain reset
//   ack_o       domain is on and usable
//   busy_o      a sequence is in progress
//   err_o       sticky power-good timeout
// Modports: slave = sequencer side, master = controller/testbench side.
interface pulp_pwr_domain_seq_if;

  logic req_i;
  logic pwr_good_i;
  logic pwr_en_o;
  logic clamp_o;
  logic rst_dom_no;
  logic ack_o;
  logic busy_o;
  logic err_o;

  modport slave (
    input  req_i, pwr_good_i,
    output pwr_en_o, clamp_o, rst_dom_no, ack_o, busy_o, err_o
  );

  modport master (
    output req_i, pwr_good_i,
    input  pwr_en_o, clamp_o, rst_dom_no, ack_o, busy_o, err_o
  );

endinterface

// File: rtl/pulp_pwr_domain_seq_sync.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset (clears both flops)
//   d_i     asynchronous input
//   q_o     synchronized output, two edges of latency
module pulp_sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/pulp_pwr_domain_seq.sv
// Power-domain on/off sequencer.
// Brings a switchable domain up (switch on, wait power-good, settle, release
// reset, release clamps) and down (clamp, assert reset, switch off, wait for
// power-good to drop). One shared down-counter times every dwell and timeout.
// Ports:
//   clk_i   sole clock
//   rst_ni  asynchronous active-low reset
//   bus     pulp_pwr_domain_seq_if.slave (request/ack and power controls)
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_OFF     | domain unpowered, clamped, in reset; waits for req
// ST_PWR_UP  | switch enabled, waiting for power-good (timed out)
// ST_SETTLE  | power-good seen, supply settling
// ST_RST_REL | domain reset released, clamps still on
// ST_ON      | domain usable, ack asserted; waits for req drop
// ST_ISO     | clamps applied ahead of reset
// ST_RST     | domain reset asserted for one cycle
// ST_PWR_DN  | switch disabled, waiting for power-good to drop (timed out)
module pulp_pwr_domain_seq
  import pulp_pwr_seq_pkg::*;
#(
  parameter int unsigned ISO_CYCLES     = DEF_ISO_CYCLES,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pulp_pwr_domain_seq_if.slave  bus
);

  localparam int unsigned CNT_MAX = max_u(max_u(ISO_CYCLES, SETTLE_CYCLES),
                                          max_u(RST_CYCLES, TIMEOUT_CYCLES));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // The counter is loaded with N-1 on entry and the exit is taken when it
  // reads zero, so exactly N cycles are spent in the state.
  localparam logic [CNT_W-1:0] ISO_LD     = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES - 1);

  pwr_state_e       state_q;
  pwr_out_t         out_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pg_s;

  pulp_sync_2ff i_pg_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.pwr_good_i),
    .q_o    (pg_s)
  );

  // Outputs are loaded together with the state register from the target
  // state, so they switch on the very edge that the state does.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_OFF;
      out_q   <= state_outputs(ST_OFF);
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (err_q) begin
            // Parked after a timeout until the requester withdraws.
            if (!bus.req_i) err_q <= 1'b0;
          end else if (bus.req_i) begin
            state_q <= ST_PWR_UP;
            out_q   <= state_outputs(ST_PWR_UP);
            cnt_q   <= TIMEOUT_LD;
          end
        end
        ST_PWR_UP: begin
          if (pg_s) begin
            state_q <= ST_SETTLE;
            out_q   <= state_outputs(ST_SETTLE);
            cnt_q   <= SETTLE_LD;
          end else if (cnt_q == '0) begin
            err_q   <= 1'b1;
            state_q <= ST_PWR_DN;
            out_q   <= state_outputs(ST_PWR_DN);
            cnt_q   <= TIMEOUT_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_RST_REL;
            out_q   <= state_outputs(ST_RST_REL);
            cnt_q   <= RST_LD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RST_REL: begin
          if (cnt_q == '0) begin
            state_q <= ST_ON;
            out_q   <= state_outputs(ST_ON);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ON: begin
          if (!bus.req_i) begin
            state_q <= ST_ISO;
            out_q   <= state_outputs(ST_ISO);
            cnt_q   <= ISO_LD;
          end
        end
        ST_ISO: begin
          if (cnt_q == '0) begin
            state_q <= ST_RST;
            out_q   <= state_outputs(ST_RST);
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RST: begin
          state_q <= ST_PWR_DN;
          out_q   <= state_outputs(ST_PWR_DN);
          cnt_q   <= TIMEOUT_LD;
        end
        ST_PWR_DN: begin
          if (!pg_s) begin
            state_q <= ST_OFF;
            out_q   <= state_outputs(ST_OFF);
          end else if (cnt_q == '0) begin
            err_q   <= 1'b1;
            state_q <= ST_OFF;
            out_q   <= state_outputs(ST_OFF);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_OFF;
          out_q   <= state_outputs(ST_OFF);
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.pwr_en_o   = out_q.pwr_en;
  assign bus.clamp_o    = out_q.clamp;
  assign bus.rst_dom_no = out_q.rst_dom_n;
  assign bus.ack_o      = out_q.ack;
  assign bus.busy_o     = out_q.busy;
  assign bus.err_o      = err_q;

endmodule

// File: doc/pulp_pwr_domain_seq.md
PULP_PWR_DOMAIN_SEQ -- requirements
Module: pulp_pwr_domain_seq

Interface
REQ-001 Parameter ISO_CYCLES, default 4, sets the clamp-setup cycles before domain reset and power-off (>=1).
REQ-002 Parameter SETTLE_CYCLES, default 8, sets the wait after synchronized power-good before reset release (>=1).
REQ-003 Parameter RST_CYCLES, default 4, sets the cycles between domain reset release and clamp release (>=1).
REQ-004 Parameter TIMEOUT_CYCLES, default 256, sets the maximum wait for a power-good edge (>=1).
REQ-005 clk_i  input  1  sole clock; all logic is on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous and active-low.
REQ-007 req_i  input  1  level request: 1 means domain on, 0 means domain off.
REQ-008 pwr_good_i  input  1  power-switch chain acknowledge, asynchronous to clk_i.
REQ-009 pwr_en_o  output  1  power-switch enable.
REQ-010 clamp_o  output  1  isolation clamp drive to the domain-output clamp cells (1 = clamped to 0).
REQ-011 rst_dom_no  output  1  active-low domain reset.
REQ-012 ack_o  output  1  is 1 only in state ON.
REQ-013 busy_o  output  1  is 1 in every state except ON and OFF.
REQ-014 err_o  output  1  sticky power-good timeout flag.

Function
REQ-015 All outputs SHALL be registered and decoded from the next state, so they change on the same edge as the state register.
REQ-016 pwr_good_i SHALL pass through a 2-flop synchronizer; every reference to power-good below means the synchronized value (pg_s).
REQ-017 States: OFF, PWR_UP, SETTLE, RST_REL, ON, ISO, RST, PWR_DN.
REQ-018 OFF: pwr_en=0, clamp=1, rst_dom_n=0; on req_i=1 and err_o=0, go to PWR_UP.
REQ-019 PWR_UP: pwr_en=1, clamp=1, rst_dom_n=0; on pg_s=1, go to SETTLE; after TIMEOUT_CYCLES without pg_s, set err_o and go to PWR_DN.
REQ-020 SETTLE: outputs as in PWR_UP; stay exactly SETTLE_CYCLES cycles, then go to RST_REL.
REQ-021 RST_REL: pwr_en=1, clamp=1, rst_dom_n=1; stay exactly RST_CYCLES cycles, then go to ON.
REQ-022 ON: pwr_en=1, clamp=0, rst_dom_n=1, ack=1; on req_i=0, go to ISO.
REQ-023 ISO: pwr_en=1, clamp=1, rst_dom_n=1; stay exactly ISO_CYCLES cycles, then go to RST.
REQ-024 RST: pwr_en=1, clamp=1, rst_dom_n=0; stay exactly 1 cycle, then go to PWR_DN.
REQ-025 PWR_DN: pwr_en=0, clamp=1, rst_dom_n=0; on pg_s=0, go to OFF; after TIMEOUT_CYCLES without pg_s=0, set err_o and go to OFF.
REQ-026 req_i SHALL be sampled only in OFF and ON; a sequence in progress always completes, and a reversed request is then honored from the stable state.
REQ-027 err_o SHALL clear only when OFF is reached with req_i=0; while err_o=1 the FSM stays in OFF.
REQ-028 Invariant: clamp_o=1 whenever pwr_en_o=0, rst_dom_no=0 or state is not ON.
REQ-029 Use one shared down-counter, width $clog2(max parameter + 1), loaded on every state entry; "stay N cycles" means N cycles are spent in the state.
REQ-030 Latency: a req_i change at edge k in a stable state SHALL produce the first output change at edge k+1.

Reset
REQ-031 On rst_ni=0, asynchronously: state=OFF, pwr_en_o=0, clamp_o=1, rst_dom_no=0, ack_o=0, busy_o=0, err_o=0, counter=0, synchronizer=0.
REQ-032 Reset asserted mid-sequence, including ON, SHALL force the OFF outputs immediately, without waiting for a clock edge.

Structure
REQ-033 Package pulp_pwr_seq_pkg SHALL hold the state enum typedef and the default cycle constants.
REQ-034 The synchronizer SHALL be a separate sub-module, pulp_sync_2ff; the FSM and the counter stay in this module.

Verification
REQ-035 Power-up: req_i 0->1, pwr_good_i rising 5 cycles later -> pwr_en_o rises at +1; rst_dom_no rises 8 cycles after pg_s; clamp_o falls and ack_o rises 4 cycles later.
REQ-036 Power-down: req_i 1->0 in ON -> clamp_o=1 at +1; rst_dom_no=0 after 4 cycles; pwr_en_o=0 one cycle later; OFF once pg_s=0.
REQ-037 Timeout: req_i=1 with pwr_good_i held 0 -> err_o=1 after 256 PWR_UP cycles, then OFF; re-entry blocked until req_i=0.
REQ-038 Reversal: req_i toggles 1->0 during SETTLE -> the up sequence completes to ON (ack_o=1 for 1 cycle), then the down sequence runs.
REQ-039 Async reset in ON -> clamp_o=1, pwr_en_o=0, rst_dom_no=0 within the same cycle, with no clock edge.
REQ-040 Assertion on all scenarios: the REQ-028 invariant never fails.
